// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
// div_for_hz gives the divisor that makes clk_out run at f_out from f_clk.
package clk_div_pkg;

    localparam int CNT_W_DEFAULT = 17;

    // clk_out completes one cycle every 2*(D+1) input cycles.
    function automatic int div_for_hz(input int f_clk, input int f_out);
        return (f_clk / (2 * f_out)) - 1;
    endfunction

    localparam int DEFAULT_DIV = div_for_hz(100_000_000, 1000);

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active and pending divisor, tick and toggled level.
// A new divisor only replaces the active one at a period boundary, a clear, or while disabled.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic             clk_out,
    output logic             pend
);

    logic [CNT_W-1:0] cnt_reg,  cnt_next;
    logic [CNT_W-1:0] div_reg,  div_next;
    logic [CNT_W-1:0] pval_reg, pval_next;
    logic             pend_reg, pend_next;
    logic             tick_reg, tick_next;
    logic             out_reg,  out_next;
    logic             terminal;
    logic [CNT_W-1:0] apply_val;

    assign terminal  = en && (cnt_reg == div_reg);
    // A write in the same cycle as the apply point wins over an older pending value.
    assign apply_val = load ? load_val : (pend_reg ? pval_reg : div_reg);

    always_comb begin
        cnt_next  = cnt_reg;
        div_next  = div_reg;
        pval_next = pval_reg;
        pend_next = pend_reg;
        tick_next = 1'b0;
        out_next  = out_reg;
        if (clr) begin
            cnt_next  = '0;
            out_next  = 1'b0;
            div_next  = apply_val;
            pend_next = 1'b0;
        end else if (!en || terminal) begin
            div_next  = apply_val;
            pend_next = 1'b0;
            if (terminal) begin
                cnt_next  = '0;
                tick_next = 1'b1;
                out_next  = ~out_reg;
            end
        end else begin
            cnt_next = cnt_reg + 1'b1;
            if (load) begin
                pval_next = load_val;
                pend_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            div_reg  <= CNT_W'(DEFAULT_DIV);
            pval_reg <= '0;
            pend_reg <= 1'b0;
            tick_reg <= 1'b0;
            out_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            div_reg  <= div_next;
            pval_reg <= pval_next;
            pend_reg <= pend_next;
            tick_reg <= tick_next;
            out_reg  <= out_next;
        end
    end

    assign tick    = tick_reg;
    assign clk_out = out_reg;
    assign pend    = pend_reg;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator: decodes divisor writes to one
// channel and fans the phase-aligning clear out to all of them.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] pend
);

    logic [NUM_CH-1:0] load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Out-of-range selects match no channel, so such writes are dropped.
            assign load[gi] = div_wr && (div_sel == SEL_W'(gi));

            clk_div_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk      (clk_100MHz),
                .rst_n    (rst_n),
                .en       (en[gi]),
                .clr      (sync_clr),
                .load     (load[gi]),
                .load_val (div_val),
                .tick     (tick[gi]),
                .clk_out  (clk_out[gi]),
                .pend     (pend[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a period-based behavioural model.
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int DDIV   = 49;
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync_clr;
    logic              div_wr;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_val;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] pend;

    int checks   = 0;
    int failures = 0;

    // Model state: cycles elapsed in the period, period length (D+1), pending period.
    int m_elapsed [NUM_CH];
    int m_period  [NUM_CH];
    int m_pperiod [NUM_CH];
    bit m_has_pend[NUM_CH];
    bit m_level   [NUM_CH];
    bit m_tick    [NUM_CH];

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sync_clr   (sync_clr),
        .div_wr     (div_wr),
        .div_sel    (div_sel),
        .div_val    (div_val),
        .tick       (tick),
        .clk_out    (clk_out),
        .pend       (pend)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        for (int c = 0; c < NUM_CH; c++) begin
            bit ld;
            bit done;
            int target;
            ld = div_wr && (int'(div_sel) == c);
            target = ld ? int'(div_val) + 1 : (m_has_pend[c] ? m_pperiod[c] : m_period[c]);
            if (!rst_n) begin
                m_elapsed[c]  = 0;
                m_period[c]   = DDIV + 1;
                m_has_pend[c] = 0;
                m_level[c]    = 0;
                m_tick[c]     = 0;
            end else if (sync_clr) begin
                m_elapsed[c]  = 0;
                m_level[c]    = 0;
                m_tick[c]     = 0;
                m_period[c]   = target;
                m_has_pend[c] = 0;
            end else begin
                done      = en[c] && (m_elapsed[c] + 1 == m_period[c]);
                m_tick[c] = done;
                if (!en[c] || done) begin
                    m_period[c]   = target;
                    m_has_pend[c] = 0;
                    if (done) begin
                        m_elapsed[c] = 0;
                        m_level[c]   = !m_level[c];
                    end
                end else begin
                    m_elapsed[c]++;
                    if (ld) begin
                        m_pperiod[c]  = int'(div_val) + 1;
                        m_has_pend[c] = 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        int et, eo, ep;
        @(posedge clk);
        model_update();
        #1;
        et = 0; eo = 0; ep = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            et |= int'(m_tick[c]) << c;
            eo |= int'(m_level[c]) << c;
            ep |= int'(m_has_pend[c]) << c;
        end
        check_eq("model_tick", int'(tick), et);
        check_eq("model_clk_out", int'(clk_out), eo);
        check_eq("model_pend", int'(pend), ep);
    endtask

    task automatic write_div(input int ch, input int val);
        div_wr  = 1'b1;
        div_sel = SEL_W'(ch);
        div_val = CNT_W'(val);
        step();
        div_wr  = 1'b0;
    endtask

    // Steps until tick[ch] is seen; returns the number of steps, or -1 on timeout.
    task automatic wait_tick(input int ch, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (tick[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int t0, t1;
        logic held;

        rst_n = 1'b0; en = '0; sync_clr = 1'b0;
        div_wr = 1'b0; div_sel = '0; div_val = '0;
        step(); step();
        check_eq("rst_tick", int'(tick), 0);
        check_eq("rst_clk_out", int'(clk_out), 0);
        check_eq("rst_pend", int'(pend), 0);

        // Default divisor: first tick D+1 cycles after release, then every D+1.
        rst_n = 1'b1; en = '1;
        wait_tick(0, 200, n);
        check_eq("first_tick_latency", n, DDIV + 1);
        check_eq("clk_out_after_1st", int'(clk_out[0]), 1);
        wait_tick(0, 200, n);
        check_eq("default_period", n, DDIV + 1);
        check_eq("clk_out_after_2nd", int'(clk_out[0]), 0);

        // Mid-period write on ch1 stays pending until the boundary.
        step(); step(); step();
        write_div(1, 9);
        check_eq("pend1_set", int'(pend[1]), 1);
        wait_tick(1, 200, n);
        check_eq("pend1_clear", int'(pend[1]), 0);
        wait_tick(1, 200, n);
        check_eq("ch1_period_10", n, 10);

        // Last write wins on ch2.
        sync_clr = 1'b1; step(); sync_clr = 1'b0;
        step(); step();
        write_div(2, 4);
        write_div(2, 7);
        check_eq("pend2_set", int'(pend[2]), 1);
        wait_tick(2, 200, n);
        check_eq("pend2_clear", int'(pend[2]), 0);
        wait_tick(2, 200, n);
        check_eq("ch2_period_8", n, 8);

        // D=0 on ch0: tick every cycle; disabling holds the level.
        write_div(0, 0);
        wait_tick(0, 200, n);
        step();
        check_eq("d0_tick_const", int'(tick[0]), 1);
        held = clk_out[0];
        step();
        check_eq("d0_toggle", int'(clk_out[0]), int'(!held));
        en[0] = 1'b0;
        step();
        check_eq("dis_tick0", int'(tick[0]), 0);
        held = clk_out[0];
        step(); step(); step();
        check_eq("dis_hold", int'(clk_out[0]), int'(held));

        // sync_clr aligns ch0 (D=3) and ch1 (D=5).
        en[0] = 1'b1;
        write_div(0, 3);
        write_div(1, 5);
        for (int i = 0; i < 15; i++) step();
        sync_clr = 1'b1; step(); sync_clr = 1'b0;
        check_eq("clr_clk_out", int'(clk_out[1:0]), 0);
        t0 = -1; t1 = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (tick[0] && t0 < 0) t0 = i;
            if (tick[1] && t1 < 0) t1 = i;
        end
        check_eq("clr_lat_ch0", t0, 4);
        check_eq("clr_lat_ch1", t1, 6);

        // Mid-period reset with an out-of-range write, then an ignored write.
        step(); step(); step();
        rst_n = 1'b0; div_wr = 1'b1; div_sel = 2'd3; div_val = 8'd1;
        step();
        rst_n = 1'b1; div_val = 8'd2;
        check_eq("mid_rst_outputs", int'({tick, clk_out, pend}), 0);
        step();
        div_wr = 1'b0;
        check_eq("ignored_wr_pend", int'(pend), 0);
        wait_tick(0, 200, n);
        check_eq("post_rst_latency", n, DDIV);

        // Maximum divisor, written while disabled: applied without pending.
        en[2] = 1'b0;
        write_div(2, 255);
        check_eq("dis_wr_no_pend", int'(pend[2]), 0);
        sync_clr = 1'b1; step(); sync_clr = 1'b0; en[2] = 1'b1;
        wait_tick(2, 400, n);
        check_eq("max_div_period", n, 256);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) en[c] = ($urandom_range(0, 7) != 0);
            div_wr   = ($urandom_range(0, 7) == 0);
            div_sel  = SEL_W'($urandom_range(0, 3));
            div_val  = CNT_W'($urandom_range(0, 12));
            sync_clr = ($urandom_range(0, 63) == 0);
            rst_n    = ($urandom_range(0, 255) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
